// File: rtl/ysyx_25040111_arb_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_25040111_arb_pkg: shared types and constants for the IFU/LSU arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ysyx_25040111_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t c_ST_IDLE = 2'd0;
  localparam arb_state_t c_ST_REQ  = 2'd1;
  localparam arb_state_t c_ST_RESP = 2'd2;
  localparam arb_state_t c_ST_ERR  = 2'd3;

  localparam logic c_MST_IFU = 1'b0;
  localparam logic c_MST_LSU = 1'b1;

  localparam logic [31:0] c_ERR_RDATA = 32'h0;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/ysyx_25040111_arb_pick.sv
// ----------------------------------------------------------------------------
// ysyx_25040111_arb_pick: combinational winner select between IFU and LSU
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ysyx_25040111_arb_pick
  import ysyx_25040111_arb_pkg::*;
#(
  parameter int RR_MODE = 1
) (
  input  logic i_ifu_valid,
  input  logic i_lsu_valid,
  input  logic i_last_grant,
  output logic o_grant_valid,
  output logic o_grant
);

  always_comb begin
    o_grant_valid = i_ifu_valid | i_lsu_valid;
    o_grant       = c_MST_IFU;
    if (i_ifu_valid && i_lsu_valid) begin
      o_grant = (RR_MODE != 0) ? ~i_last_grant : c_MST_LSU;
    end else if (i_lsu_valid) begin
      o_grant = c_MST_LSU;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_25040111_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_25040111_mem_arbiter: shares one memory port between IFU and LSU
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ysyx_25040111_mem_arbiter
  import ysyx_25040111_arb_pkg::*;
#(
  parameter int RR_MODE        = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [31:0] resp_rdata,
  output logic        timeout_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata
);

  localparam int c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = '1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST =
    c_CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_t         r_state;
  arb_state_t         w_next;
  mem_req_t           r_req;
  logic               r_owner;
  logic               r_last_grant;
  logic [c_CNT_W-1:0] r_cnt;
  logic               w_grant_valid;
  logic               w_grant;
  logic               w_accept;
  logic               w_timeout;

  ysyx_25040111_arb_pick #(
    .RR_MODE(RR_MODE)
  ) u_pick (
    .i_ifu_valid  (ifu_req_valid),
    .i_lsu_valid  (lsu_req_valid),
    .i_last_grant (r_last_grant),
    .o_grant_valid(w_grant_valid),
    .o_grant      (w_grant)
  );

  assign w_accept  = (r_state == c_ST_IDLE) && w_grant_valid;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == c_CNT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE: if (w_accept) w_next = c_ST_REQ;
      c_ST_REQ:  if (mem_req_ready) w_next = c_ST_RESP;
      c_ST_RESP: begin
        if (mem_resp_valid) w_next = c_ST_IDLE;
        else if (w_timeout) w_next = c_ST_ERR;
      end
      default:   w_next = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_req        <= '0;
      r_owner      <= c_MST_IFU;
      r_last_grant <= c_MST_IFU;
      r_cnt        <= '0;
    end else begin
      if (w_accept) begin
        r_owner      <= w_grant;
        r_last_grant <= w_grant;
        r_req        <= (w_grant == c_MST_LSU) ?
                        '{addr: lsu_addr, wen: lsu_wen, wdata: lsu_wdata, wmask: lsu_wmask} :
                        '{addr: ifu_addr, wen: 1'b0, wdata: 32'h0, wmask: 4'h0};
      end
      // Saturating so a disabled timeout can sit in RESP forever without wrapping.
      if (r_state == c_ST_REQ && mem_req_ready) begin
        r_cnt <= '0;
      end else if (r_state == c_ST_RESP && !mem_resp_valid && r_cnt != c_CNT_MAX) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
    end
  end

  assign mem_addr  = r_req.addr;
  assign mem_wen   = r_req.wen;
  assign mem_wdata = r_req.wdata;
  assign mem_wmask = r_req.wmask;

  always_comb begin
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    resp_rdata     = c_ERR_RDATA;
    timeout_err    = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        // Gated by reset so no ready leaks out while the reset is asserted.
        if (reset && w_grant_valid) begin
          ifu_req_ready = (w_grant == c_MST_IFU);
          lsu_req_ready = (w_grant == c_MST_LSU);
        end
      end
      c_ST_REQ: mem_req_valid = 1'b1;
      c_ST_RESP: begin
        if (mem_resp_valid) begin
          ifu_resp_valid = (r_owner == c_MST_IFU);
          lsu_resp_valid = (r_owner == c_MST_LSU);
          resp_rdata     = mem_rdata;
        end
      end
      default: begin
        ifu_resp_valid = (r_owner == c_MST_IFU);
        lsu_resp_valid = (r_owner == c_MST_LSU);
        resp_rdata     = c_ERR_RDATA;
        timeout_err    = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire
